// File: rtl/closest_hit_reducer_if.sv
// Hit record package and valid/ready bus interface for the closest-hit reducer.
// The null voxel index can be overridden by defining NULL_VOXEL_INDEX before this file.
`ifndef NULL_VOXEL_INDEX
`define NULL_VOXEL_INDEX 16'hFFFF
`endif

package closest_hit_pkg;
    localparam int unsigned T_W      = 32;  // signed 16.16 fixed-point distance
    localparam int unsigned VI_W     = 16;
    localparam int unsigned COLOR_W  = 24;
    localparam int unsigned STYPE_W  = 2;
    localparam int unsigned NORMAL_W = 3;

    typedef struct packed {
        logic                  b_hit;
        logic signed [T_W-1:0] t;
        logic [VI_W-1:0]       vi;
        logic [COLOR_W-1:0]    color;
        logic [STYPE_W-1:0]    surface_type;
        logic [NORMAL_W-1:0]   normal;
    } hit_t;

    localparam hit_t NO_HIT = '{b_hit: 1'b0, t: '0, vi: VI_W'(`NULL_VOXEL_INDEX),
                                color: '0, surface_type: '0, normal: '0};
endpackage

interface closest_hit_if #(parameter int unsigned CNT_W = 8);
    import closest_hit_pkg::*;

    logic             start_valid;
    logic             start_ready;
    logic             start_any_hit;
    logic             cand_valid;
    logic             cand_ready;
    logic             cand_last;
    hit_t             cand_hit;
    logic             out_valid;
    logic             out_ready;
    hit_t             out_hit;
    logic [CNT_W-1:0] out_count;

    modport master (
        output start_valid, start_any_hit, cand_valid, cand_last, cand_hit, out_ready,
        input  start_ready, cand_ready, out_valid, out_hit, out_count
    );

    modport slave (
        input  start_valid, start_any_hit, cand_valid, cand_last, cand_hit, out_ready,
        output start_ready, cand_ready, out_valid, out_hit, out_count
    );
endinterface

// File: rtl/closest_hit_reducer.sv
// Reduces the stream of AABB hit candidates for one ray to the nearest hit.
// Optional feature: define ANYHIT_EARLY_OUT_EN to finish shadow rays on their first hit.
module closest_hit_reducer
    import closest_hit_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic          clk,
    input  logic          resetn,
    closest_hit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state, state_next;
    hit_t             best, best_next;
    logic [CNT_W-1:0] count, count_next;
    logic             start_rdy, start_rdy_next;
    logic             cand_rdy, cand_rdy_next;
    logic             res_valid, res_valid_next;

    logic start_fire, cand_fire, out_fire, replace;

`ifdef ANYHIT_EARLY_OUT_EN
    logic any_hit, any_hit_next;
    logic drain, drain_next;   // still swallowing the tail of an early-out ray
    logic taken, taken_next;   // result already handed to the consumer
`else
    logic unused_any_hit;
    assign unused_any_hit = bus.start_any_hit;
`endif

    assign start_fire = bus.start_valid & start_rdy;
    assign cand_fire  = bus.cand_valid & cand_rdy;
    assign out_fire   = res_valid & bus.out_ready;

    // Strictly nearer hit wins; equal distance keeps the earlier candidate
    assign replace = bus.cand_hit.b_hit &&
                     (!best.b_hit || ($signed(bus.cand_hit.t) < $signed(best.t)));

    assign bus.start_ready = start_rdy;
    assign bus.cand_ready  = cand_rdy;
    assign bus.out_valid   = res_valid;
    assign bus.out_hit     = best;
    assign bus.out_count   = count;

    // Next-state, datapath update and next values of the registered outputs
    always_comb begin
        state_next = state;
        best_next  = best;
        count_next = count;
`ifdef ANYHIT_EARLY_OUT_EN
        any_hit_next = any_hit;
        drain_next   = drain;
        taken_next   = taken;
`endif
        case (state)
            IDLE: begin
                if (start_fire) begin
                    best_next  = NO_HIT;
                    count_next = '0;
                    state_next = ACCUM;
`ifdef ANYHIT_EARLY_OUT_EN
                    any_hit_next = bus.start_any_hit;
                    drain_next   = 1'b0;
                    taken_next   = 1'b0;
`endif
                end
            end
            ACCUM: begin
                if (cand_fire) begin
                    if (count != {CNT_W{1'b1}}) begin
                        count_next = count + CNT_W'(1);
                    end
                    if (replace) begin
                        best_next = bus.cand_hit;
                    end
                    if (bus.cand_last) begin
                        state_next = DONE;
                    end
`ifdef ANYHIT_EARLY_OUT_EN
                    else if (any_hit && bus.cand_hit.b_hit) begin
                        state_next = DONE;
                        drain_next = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
`ifdef ANYHIT_EARLY_OUT_EN
                if (out_fire) begin
                    taken_next = 1'b1;
                end
                if (drain && cand_fire && bus.cand_last) begin
                    drain_next = 1'b0;
                end
                if (taken_next && !drain_next) begin
                    state_next = IDLE;
                end
`else
                if (out_fire) begin
                    state_next = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase

        start_rdy_next = (state_next == IDLE);
`ifdef ANYHIT_EARLY_OUT_EN
        cand_rdy_next  = (state_next == ACCUM) || drain_next;
        res_valid_next = (state_next == DONE) && !taken_next;
`else
        cand_rdy_next  = (state_next == ACCUM);
        res_valid_next = (state_next == DONE);
`endif
    end

    // State, best-hit/count registers and registered handshake outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            best      <= NO_HIT;
            count     <= '0;
            start_rdy <= 1'b0;
            cand_rdy  <= 1'b0;
            res_valid <= 1'b0;
`ifdef ANYHIT_EARLY_OUT_EN
            any_hit   <= 1'b0;
            drain     <= 1'b0;
            taken     <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            best      <= best_next;
            count     <= count_next;
            start_rdy <= start_rdy_next;
            cand_rdy  <= cand_rdy_next;
            res_valid <= res_valid_next;
`ifdef ANYHIT_EARLY_OUT_EN
            any_hit   <= any_hit_next;
            drain     <= drain_next;
            taken     <= taken_next;
`endif
        end
    end

endmodule
